// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Round-robin, burst-limited arbiter sharing one synchronous
//                FIFO write port between NUM_REQ producers.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 16,
   parameter int MAX_BURST  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] data,
   input  logic                          full,
   output logic [NUM_REQ-1:0]            gnt,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_data,
   output logic [$clog2(NUM_REQ)-1:0]    owner,
   output logic [3:0]                    burst_cnt
);

   localparam int                 c_idx_w     = $clog2(NUM_REQ);
   localparam logic [3:0]         c_max_burst = 4'(MAX_BURST);
   localparam logic [c_idx_w-1:0] c_last      = c_idx_w'(NUM_REQ - 1);
   localparam logic [c_idx_w:0]   c_num_req   = (c_idx_w + 1)'(NUM_REQ);

   logic [c_idx_w-1:0] r_owner;
   logic [3:0]         r_burst;
   logic               w_keep;
   logic               w_win_vld;
   logic [c_idx_w-1:0] w_win;
   logic [c_idx_w:0]   w_sum;
   logic [c_idx_w-1:0] w_cand;

   // Owner keeps the port only while its burst is open and not yet at the limit.
   assign w_keep = req[r_owner] && (r_burst != 4'd0) && (r_burst < c_max_burst);

   // Round-robin scan starts after the owner and visits the owner last, so an
   // exhausted owner regains the port only when nobody else is asking.
   always_comb begin
      w_win_vld = 1'b0;
      w_win     = '0;
      w_sum     = '0;
      w_cand    = '0;
      if (!rst && !full) begin
         if (w_keep) begin
            w_win_vld = 1'b1;
            w_win     = r_owner;
         end else begin
            for (int i = 1; i <= NUM_REQ; i++) begin
               w_sum = {1'b0, r_owner} + (c_idx_w + 1)'(i);
               if (w_sum >= c_num_req) begin
                  w_sum = w_sum - c_num_req;
               end
               w_cand = w_sum[c_idx_w-1:0];
               if (!w_win_vld && req[w_cand]) begin
                  w_win_vld = 1'b1;
                  w_win     = w_cand;
               end
            end
         end
      end
   end

   always_comb begin
      gnt = '0;
      if (w_win_vld) begin
         gnt[w_win] = 1'b1;
      end
   end

   always_comb begin
      fifo_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            fifo_data = data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign fifo_wr_en = w_win_vld;

   // A full stall freezes the burst; an idle cycle (no requests) closes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner <= c_last;
         r_burst <= 4'd0;
      end else if (w_win_vld) begin
         if (w_win == r_owner) begin
            r_burst <= (r_burst < c_max_burst) ? r_burst + 4'd1 : 4'd1;
         end else begin
            r_owner <= w_win;
            r_burst <= 4'd1;
         end
      end else if (!full) begin
         r_burst <= 4'd0;
      end
   end

   assign owner     = r_owner;
   assign burst_cnt = r_burst;

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of the team's synchronous FIFO between NUM_REQ independent producers. Each producer presents a request plus data. The arbiter picks at most one winner per cycle and drives the FIFO's wr_en/data_in directly. It never issues a write while the FIFO reports full. Burst limiting keeps a streaming producer from starving the others.

## Interface
- NUM_REQ, 4: number of producers; legal range 2–8.
- DATA_WIDTH, 16: data width; must match the FIFO's data_in width.
- MAX_BURST, 4: maximum consecutive writes by one owner before forced rotation; legal range 1–15.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- req  in  NUM_REQ  per-producer write request.
- data  in  NUM_REQ*DATA_WIDTH  packed producer data; producer i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
- full  in  1  FIFO full flag, same cycle.
- gnt  out  NUM_REQ  one-hot (or zero) grant; a write is accepted in any cycle where req[i] && gnt[i].
- fifo_wr_en  out  1  write enable to the FIFO; equals |gnt.
- fifo_data  out  DATA_WIDTH  data of the granted producer; all zeros when no grant.
- owner  out  $clog2(NUM_REQ)  index of the last granted producer (registered).
- burst_cnt  out  4  consecutive writes by the current owner (registered).

## Operation
- Grant is combinational from req, full, owner and burst_cnt. At most one gnt bit is high, and only for a requesting producer.
- full=1 or rst=1: gnt=0, fifo_wr_en=0, fifo_data=0. Registered state holds during full and is cleared by rst.
- Priority search: the candidate list starts with the keep-owner rule, then falls back to round-robin.
  - Keep-owner: if req[owner]=1 and 0 < burst_cnt < MAX_BURST, owner wins again.
  - Otherwise round-robin from owner+1 (mod NUM_REQ) upward; the first set req bit wins.
  - Once burst_cnt reaches MAX_BURST, the owner can win again only if no other producer is requesting.
- Register update on each granted cycle (winner w):
  - If w == owner and burst_cnt < MAX_BURST: burst_cnt <= burst_cnt+1.
  - If w == owner and burst_cnt == MAX_BURST (sole requester): burst_cnt <= 1.
  - Otherwise: owner <= w, burst_cnt <= 1.
- No-grant cycle because req=0: burst_cnt <= 0; owner unchanged. This ends the burst; the next round-robin search still starts after owner.
- No-grant cycle because full=1: owner and burst_cnt unchanged. The burst resumes once full drops.
- Producers must hold req and data stable until they see gnt. A producer may drop req without penalty.
- A req bit for an out-of-range index cannot occur; no error handling is required.

## Timing
- Reset: owner = NUM_REQ-1, so producer 0 has first priority after reset; burst_cnt = 0. gnt, fifo_wr_en and fifo_data are 0 while rst is high.
- Latency: zero cycles from req to gnt/fifo_wr_en (combinational). The FIFO captures fifo_data on the same rising edge that updates owner/burst_cnt.
- Throughput: one write per cycle while the FIFO is not full.
- full is sampled in the same cycle as the grant; the FIFO must drop full combinationally or registered-ahead so that no overflow write occurs.
- Simultaneous full rising and a request: no grant, no write.
- Reset mid-burst: the next cycle after rst deassertion behaves exactly as after power-up reset.
- Wrap-around: the round-robin search wraps from NUM_REQ-1 to 0. The owner index wraps the same way.

## Test plan
- Reset then single requester: rst 2 cycles, req=4'b0100 for 6 cycles, full=0.
  - Expect gnt=4'b0100 every cycle and 6 FIFO writes.
  - burst_cnt sequence 1,2,3,4,1,2 (sole-requester reuse); owner=2.
- All requesting, MAX_BURST=4: req=4'b1111 for 16 cycles.
  - Expect grant order 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3.
  - Expect exactly 4 writes per producer.
- Full backpressure: producer 1 streaming at burst_cnt=2; raise full for 3 cycles.
  - Expect gnt=0, fifo_wr_en=0, owner=1, burst_cnt=2 held.
  - After full drops: two more grants to producer 1, then rotation.
- Owner drops req: producer 0 at burst_cnt=2 deasserts req while req[3]=1.
  - Expect the next grant to go to producer 3 with burst_cnt=1.
  - With req=0 for one cycle: burst_cnt=0, owner unchanged.
- Wrap-around: owner=3, req=4'b0011.
  - Expect the winner is producer 0, then producer 0 keeps grant up to 4 writes, then producer 1.
- Reset mid-burst: assert rst during producer 2's third write with req=4'b1111.
  - Expect outputs 0 during rst; after release, first grant goes to producer 0 with burst_cnt=1.
  - Scoreboard: FIFO contents equal the granted data in grant order; no write ever occurs with full=1.
